// File: rtl/pfw_in_arb_pkg.sv
// rtl/pfw_in_arb_pkg.sv - shared constants and state encoding for the pfw input arbiter
//
// Purpose : packet-tag constants carried in word bits [133:132], the packet bus
//           width, and the arbiter state encoding.
// Ports   : none (package).
package pfw_in_arb_pkg;

    localparam int DATA_W = 134;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pfw_rr_pick.sv
// rtl/pfw_rr_pick.sv - two-way strict-priority / round-robin grant selector
//
// Purpose : picks one of two requesters; purely combinational.
// Ports   : req_i[1:0]  request per source
//           ptr_i       favoured source on a tie (round-robin mode)
//           mode_i      1 = source 1 strict priority, 0 = round-robin
//           gnt_o       granted source index
//           gnt_vld_o   at least one request present
module pfw_rr_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       mode_i,
    output logic       gnt_o,
    output logic       gnt_vld_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        gnt_o     = 1'b0;
        if (mode_i) begin
            gnt_o = req_i[1];
        end else if (&req_i) begin
            gnt_o = ptr_i;
        end else begin
            // Single requester (or none): whoever asks wins.
            gnt_o = req_i[1];
        end
    end

endmodule

// File: rtl/pfw_in_arb.sv
// rtl/pfw_in_arb.sv - two-source whole-packet arbiter feeding the forwarding stage
//
// Purpose : forwards whole packets from two show-ahead data/valid FIFO pairs onto
//           one 134-bit bus, with a per-packet length guard and head check.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           in_srcN_data/_data_empty      source N data FIFO word / empty
//           out_srcN_data_rd              source N data FIFO pop
//           in_srcN_valid/_valid_empty    source N per-packet valid / empty
//           out_srcN_valid_rd             source N valid FIFO pop
//           in_dst_alf                    downstream almost-full (gates new grants)
//           out_pfw_data/_data_wr         forwarded word and strobe
//           out_pfw_valid/_valid_wr       packet keep/discard bit and strobe
//           out_pkt_err                   guard-trip pulse
//           out_grant_src                 source of the packet in flight
// Options : PFW_IN_ARB_STAT_EN adds out_src0_pkt_cnt, out_src1_pkt_cnt, out_err_cnt.
module pfw_in_arb
    import pfw_in_arb_pkg::*;
#(
    parameter int PRIO_MODE     = 1,
    parameter int MAX_PKT_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_src0_data,
    input  logic              in_src0_data_empty,
    output logic              out_src0_data_rd,
    input  logic              in_src0_valid,
    input  logic              in_src0_valid_empty,
    output logic              out_src0_valid_rd,
    input  logic [DATA_W-1:0] in_src1_data,
    input  logic              in_src1_data_empty,
    output logic              out_src1_data_rd,
    input  logic              in_src1_valid,
    input  logic              in_src1_valid_empty,
    output logic              out_src1_valid_rd,
    input  logic              in_dst_alf,
    output logic [DATA_W-1:0] out_pfw_data,
    output logic              out_pfw_data_wr,
    output logic              out_pfw_valid,
    output logic              out_pfw_valid_wr,
    output logic              out_pkt_err,
    output logic              out_grant_src
`ifdef PFW_IN_ARB_STAT_EN
    ,
    output logic [31:0]       out_src0_pkt_cnt,
    output logic [31:0]       out_src1_pkt_cnt,
    output logic [31:0]       out_err_cnt
`endif
);

    localparam logic [7:0] MAX_W = 8'(MAX_PKT_WORDS);

    arb_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              grant_q;
    logic              ptr_q;
    logic [DATA_W-1:0] pfw_data_q;
    logic              data_wr_q, pfw_valid_q, valid_wr_q, err_q;

    logic [1:0]        src_req;
    logic              pick, pick_vld;

    logic [DATA_W-1:0] cur_data;
    logic              cur_empty, cur_valid, is_tail;
    logic [1:0]        cur_tag;
    logic              data_pop, valid_pop, trip, pkt_end, grant_now;

    // A packet is only eligible once its valid entry exists, so its words are
    // already committed and the packet can be streamed without interleaving.
    assign src_req = {!in_src1_valid_empty, !in_src0_valid_empty};

    pfw_rr_pick u_pick (
        .req_i     (src_req),
        .ptr_i     (ptr_q),
        .mode_i    (PRIO_MODE != 0),
        .gnt_o     (pick),
        .gnt_vld_o (pick_vld)
    );

    always_comb begin
        cur_data  = grant_q ? in_src1_data       : in_src0_data;
        cur_empty = grant_q ? in_src1_data_empty : in_src0_data_empty;
        cur_valid = grant_q ? in_src1_valid      : in_src0_valid;
        cur_tag   = cur_data[DATA_W-1 -: 2];
        is_tail   = (cur_tag == TAG_TAIL);
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_pop  = 1'b0;
        valid_pop = 1'b0;
        trip      = 1'b0;
        pkt_end   = 1'b0;
        grant_now = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!in_dst_alf && pick_vld) begin
                    grant_now = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!cur_empty) begin
                    data_pop = 1'b1;
                    cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    // A bad first word or the length limit without a tail both
                    // discard the packet; the valid entry is retired right away
                    // so the source is not re-granted on a stale entry.
                    if ((cnt_q == 8'd0 && cur_tag != TAG_HEAD) ||
                        (!is_tail && cnt_d == MAX_W)) begin
                        trip      = 1'b1;
                        valid_pop = 1'b1;
                        pkt_end   = is_tail;
                        state_d   = is_tail ? ST_IDLE : ST_DRAIN;
                    end else if (is_tail) begin
                        valid_pop = 1'b1;
                        pkt_end   = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!cur_empty) begin
                    data_pop = 1'b1;
                    if (is_tail) begin
                        pkt_end = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            data_pop  = 1'b0;
            valid_pop = 1'b0;
        end
    end

    assign out_src0_data_rd  = data_pop  && !grant_q;
    assign out_src1_data_rd  = data_pop  &&  grant_q;
    assign out_src0_valid_rd = valid_pop && !grant_q;
    assign out_src1_valid_rd = valid_pop &&  grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 8'd0;
            grant_q     <= 1'b0;
            ptr_q       <= 1'b0;
            pfw_data_q  <= '0;
            data_wr_q   <= 1'b0;
            pfw_valid_q <= 1'b0;
            valid_wr_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            data_wr_q  <= 1'b0;
            valid_wr_q <= 1'b0;
            err_q      <= 1'b0;
            if (grant_now) begin
                grant_q <= pick;
            end
            if (pkt_end) begin
                ptr_q <= ~grant_q;
            end
            if (data_pop && state_q == ST_SEND) begin
                pfw_data_q <= cur_data;
                data_wr_q  <= 1'b1;
            end
            if (valid_pop) begin
                valid_wr_q  <= 1'b1;
                pfw_valid_q <= cur_valid && !trip;
            end
            if (trip) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_pfw_data     = pfw_data_q;
    assign out_pfw_data_wr  = data_wr_q;
    assign out_pfw_valid    = pfw_valid_q;
    assign out_pfw_valid_wr = valid_wr_q;
    assign out_pkt_err      = err_q;
    assign out_grant_src    = grant_q;

`ifdef PFW_IN_ARB_STAT_EN
    logic [31:0] src0_cnt_q, src1_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src0_cnt_q <= 32'd0;
            src1_cnt_q <= 32'd0;
            err_cnt_q  <= 32'd0;
        end else begin
            if (pkt_end && !grant_q) src0_cnt_q <= src0_cnt_q + 32'd1;
            if (pkt_end &&  grant_q) src1_cnt_q <= src1_cnt_q + 32'd1;
            if (trip)                err_cnt_q  <= err_cnt_q + 32'd1;
        end
    end

    assign out_src0_pkt_cnt = src0_cnt_q;
    assign out_src1_pkt_cnt = src1_cnt_q;
    assign out_err_cnt      = err_cnt_q;
`endif

endmodule

// File: tb/tb_pfw_in_arb.sv
// tb/tb_pfw_in_arb.sv - self-checking bench: round-robin and strict-priority arbiters against a packet-level model
module tb_pfw_in_arb;

    localparam int MAXW = 8;
    localparam int NPK  = 256;

    logic clk = 1'b0;
    logic rst;
    logic alf;
    always #5 clk = ~clk;

    // Index [k] selects the instance: 0 = round-robin, 1 = source 1 priority.
    logic [133:0] s_data   [2][2];
    logic         s_dempty [2][2];
    logic         s_vld    [2][2];
    logic         s_vempty [2][2];
    logic         d_rd     [2][2];
    logic         v_rd     [2][2];
    logic [133:0] o_data [2];
    logic         o_dwr [2];
    logic         o_vld [2];
    logic         o_vwr [2];
    logic         o_err [2];
    logic         o_gnt [2];
`ifdef PFW_IN_ARB_STAT_EN
    logic [31:0]  st_c0 [2];
    logic [31:0]  st_c1 [2];
    logic [31:0]  st_e  [2];
`endif

    pfw_in_arb #(.PRIO_MODE(0), .MAX_PKT_WORDS(MAXW)) u_rr (
        .clk(clk), .rst(rst),
        .in_src0_data(s_data[0][0]), .in_src0_data_empty(s_dempty[0][0]), .out_src0_data_rd(d_rd[0][0]),
        .in_src0_valid(s_vld[0][0]), .in_src0_valid_empty(s_vempty[0][0]), .out_src0_valid_rd(v_rd[0][0]),
        .in_src1_data(s_data[0][1]), .in_src1_data_empty(s_dempty[0][1]), .out_src1_data_rd(d_rd[0][1]),
        .in_src1_valid(s_vld[0][1]), .in_src1_valid_empty(s_vempty[0][1]), .out_src1_valid_rd(v_rd[0][1]),
        .in_dst_alf(alf),
        .out_pfw_data(o_data[0]), .out_pfw_data_wr(o_dwr[0]),
        .out_pfw_valid(o_vld[0]), .out_pfw_valid_wr(o_vwr[0]),
        .out_pkt_err(o_err[0]), .out_grant_src(o_gnt[0])
`ifdef PFW_IN_ARB_STAT_EN
        , .out_src0_pkt_cnt(st_c0[0]), .out_src1_pkt_cnt(st_c1[0]), .out_err_cnt(st_e[0])
`endif
    );

    pfw_in_arb #(.PRIO_MODE(1), .MAX_PKT_WORDS(MAXW)) u_sp (
        .clk(clk), .rst(rst),
        .in_src0_data(s_data[1][0]), .in_src0_data_empty(s_dempty[1][0]), .out_src0_data_rd(d_rd[1][0]),
        .in_src0_valid(s_vld[1][0]), .in_src0_valid_empty(s_vempty[1][0]), .out_src0_valid_rd(v_rd[1][0]),
        .in_src1_data(s_data[1][1]), .in_src1_data_empty(s_dempty[1][1]), .out_src1_data_rd(d_rd[1][1]),
        .in_src1_valid(s_vld[1][1]), .in_src1_valid_empty(s_vempty[1][1]), .out_src1_valid_rd(v_rd[1][1]),
        .in_dst_alf(alf),
        .out_pfw_data(o_data[1]), .out_pfw_data_wr(o_dwr[1]),
        .out_pfw_valid(o_vld[1]), .out_pfw_valid_wr(o_vwr[1]),
        .out_pkt_err(o_err[1]), .out_grant_src(o_gnt[1])
`ifdef PFW_IN_ARB_STAT_EN
        , .out_src0_pkt_cnt(st_c0[1]), .out_src1_pkt_cnt(st_c1[1]), .out_err_cnt(st_e[1])
`endif
    );

    // Source FIFO contents and packet-level reference state.
    logic [133:0] dq [2][2][$];
    bit           vq [2][2][$];
    bit           stall [2][2];
    bit           rnd_stall;
    int           pend [2][2][$];
    logic [133:0] pw [NPK][$];
    bit           pvld [NPK];
    bit           pbad [NPK];
    int           npk;
    logic [133:0] exp_w [2][$];
    bit           exp_g [2][$];
    bit           exp_v [2][$];
    int           exp_err [2];
    logic [133:0] obs_w [2][$];
    bit           obs_g [2][$];
    bit           obs_v [2][$];
    int           obs_err [2];
    bit           mptr [2];
    int           cyc;
    int           npops;
    int           pop_cyc [$];
    int           wr_cyc [$];
    int           vwr_cyc [$];
    int           checks, errors;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                s_dempty[k][s] = (dq[k][s].size() == 0) || stall[k][s];
                s_data[k][s]   = (dq[k][s].size() != 0) ? dq[k][s][0] : '0;
                s_vempty[k][s] = (vq[k][s].size() == 0);
                s_vld[k][s]    = (vq[k][s].size() != 0) ? vq[k][s][0] : 1'b0;
            end
        end
    endtask

    function automatic bit fifos_empty();
        bit e;
        e = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 2; s++)
                if (dq[k][s].size() != 0 || vq[k][s].size() != 0) e = 1'b0;
        return e;
    endfunction

    // One clock: observe at the falling edge, let the FIFOs pop after the rising edge.
    task automatic tick();
        bit prd [2][2];
        bit pvr [2][2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (o_dwr[k] === 1'b1) begin
                obs_w[k].push_back(o_data[k]);
                obs_g[k].push_back(o_gnt[k]);
                if (k == 0) wr_cyc.push_back(cyc);
            end
            if (o_vwr[k] === 1'b1) begin
                obs_v[k].push_back(o_vld[k]);
                if (k == 0) vwr_cyc.push_back(cyc);
            end
            if (o_err[k] === 1'b1) obs_err[k]++;
            for (int s = 0; s < 2; s++) begin
                prd[k][s] = (d_rd[k][s] === 1'b1);
                pvr[k][s] = (v_rd[k][s] === 1'b1);
                if (prd[k][s] || pvr[k][s]) begin
                    check($sformatf("pop_owner_d%0d_s%0d", k, s), 134'(o_gnt[k]), 134'(s));
                    npops++;
                end
                if (prd[k][s]) check($sformatf("pop_nonempty_d%0d_s%0d", k, s), 134'(s_dempty[k][s]), 134'(0));
                if (pvr[k][s]) check($sformatf("vpop_nonempty_d%0d_s%0d", k, s), 134'(s_vempty[k][s]), 134'(0));
                if (k == 0 && s == 0 && prd[k][s]) pop_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (prd[k][s] && dq[k][s].size() != 0) void'(dq[k][s].pop_front());
                if (pvr[k][s] && vq[k][s].size() != 0) void'(vq[k][s].pop_front());
                if (rnd_stall) stall[k][s] = ($urandom_range(0, 3) == 0);
            end
        end
        refresh();
        cyc++;
    endtask

    // Same packet is offered to both instances.
    task automatic push_pkt(input int s, input int len, input bit vld, input bit bad);
        int id;
        logic [1:0]   tag;
        logic [131:0] pay;
        id = npk;
        npk++;
        pw[id].delete();
        for (int i = 0; i < len; i++) begin
            if (i == len - 1)  tag = 2'b10;
            else if (i == 0)   tag = bad ? 2'b11 : 2'b01;
            else               tag = 2'b11;
            pay = {$urandom, $urandom, $urandom, $urandom, 4'($urandom)};
            pw[id].push_back({tag, pay});
            for (int k = 0; k < 2; k++) dq[k][s].push_back({tag, pay});
        end
        pvld[id] = vld;
        pbad[id] = bad;
        for (int k = 0; k < 2; k++) begin
            vq[k][s].push_back(vld);
            pend[k][s].push_back(id);
        end
        refresh();
    endtask

    // Whole-packet reference: which source goes next, how many words come out, keep bit.
    task automatic model_run(input int first);
        int g, id, nout;
        bit r0, r1, v, started;
        for (int k = 0; k < 2; k++) begin
            started = 1'b0;
            while (pend[k][0].size() + pend[k][1].size() != 0) begin
                r0 = (pend[k][0].size() != 0);
                r1 = (pend[k][1].size() != 0);
                if (!started && first >= 0) g = first;
                else if (k == 1)            g = r1 ? 1 : 0;
                else if (r0 && r1)          g = mptr[k] ? 1 : 0;
                else                        g = r1 ? 1 : 0;
                started = 1'b1;
                id = pend[k][g].pop_front();
                if (pbad[id]) begin
                    nout = 1; v = 1'b0; exp_err[k]++;
                end else if (pw[id].size() > MAXW) begin
                    nout = MAXW; v = 1'b0; exp_err[k]++;
                end else begin
                    nout = pw[id].size(); v = pvld[id];
                end
                for (int i = 0; i < nout; i++) begin
                    exp_w[k].push_back(pw[id][i]);
                    exp_g[k].push_back(g != 0);
                end
                exp_v[k].push_back(v);
                mptr[k] = (g == 0);
            end
        end
    endtask

    task automatic compare(input string tag);
        int n;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_d%0d_nwords", tag, k), 134'(obs_w[k].size()), 134'(exp_w[k].size()));
            n = (obs_w[k].size() < exp_w[k].size()) ? obs_w[k].size() : exp_w[k].size();
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_d%0d_word%0d", tag, k, i), obs_w[k][i], exp_w[k][i]);
                check($sformatf("%s_d%0d_gnt%0d", tag, k, i), 134'(obs_g[k][i]), 134'(exp_g[k][i]));
            end
            check($sformatf("%s_d%0d_nvalid", tag, k), 134'(obs_v[k].size()), 134'(exp_v[k].size()));
            n = (obs_v[k].size() < exp_v[k].size()) ? obs_v[k].size() : exp_v[k].size();
            for (int i = 0; i < n; i++)
                check($sformatf("%s_d%0d_valid%0d", tag, k, i), 134'(obs_v[k][i]), 134'(exp_v[k][i]));
            check($sformatf("%s_d%0d_errs", tag, k), 134'(obs_err[k]), 134'(exp_err[k]));
            obs_w[k].delete(); obs_g[k].delete(); obs_v[k].delete();
            exp_w[k].delete(); exp_g[k].delete(); exp_v[k].delete();
            obs_err[k] = 0; exp_err[k] = 0;
        end
    endtask

    task automatic run_done(input int budget);
        int n;
        n = 0;
        while (!fifos_empty() && n < budget) begin
            tick();
            n++;
        end
        check("drain_budget", 134'(fifos_empty()), 134'(1));
        repeat (4) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_d%0d_data", tag, k), o_data[k], '0);
            check($sformatf("%s_d%0d_dwr", tag, k), 134'(o_dwr[k]), 134'(0));
            check($sformatf("%s_d%0d_vld", tag, k), 134'(o_vld[k]), 134'(0));
            check($sformatf("%s_d%0d_vwr", tag, k), 134'(o_vwr[k]), 134'(0));
            check($sformatf("%s_d%0d_err", tag, k), 134'(o_err[k]), 134'(0));
            check($sformatf("%s_d%0d_gnt", tag, k), 134'(o_gnt[k]), 134'(0));
            check($sformatf("%s_d%0d_rd", tag, k),
                  134'({d_rd[k][0], d_rd[k][1], v_rd[k][0], v_rd[k][1]}), 134'(0));
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0;
        checks = 0; errors = 0; npk = 0; cyc = 0; npops = 0;
        rnd_stall = 1'b0; alf = 1'b0; rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mptr[k] = 1'b0; exp_err[k] = 0; obs_err[k] = 0;
            for (int s = 0; s < 2; s++) stall[k][s] = 1'b0;
        end
        refresh();
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        obs_w[0].delete(); obs_w[1].delete();

        // Both sources loaded while almost-full holds back grants, then released.
        alf = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_pkt(0, $urandom_range(3, 6), 1'($urandom_range(0, 1)), 1'b0);
            push_pkt(1, $urandom_range(3, 6), 1'($urandom_range(0, 1)), 1'b0);
        end
        p0 = npops;
        repeat (8) tick();
        check("alf_idle_no_pop", 134'(npops - p0), 134'(0));
        check("alf_idle_no_wr", 134'(obs_w[0].size() + obs_w[1].size()), 134'(0));
        alf = 1'b0;
        run_done(400);
        model_run(-1);
        compare("rr_both");

        // Almost-full raised mid-packet: the packet finishes, the next one waits.
        push_pkt(0, 8, 1'b1, 1'b0);
        push_pkt(1, 5, 1'b1, 1'b0);
        n = 0;
        while (obs_w[0].size() < 2 && n < 20) begin tick(); n++; end
        check("alf_mid_started", 134'(obs_w[0].size() >= 2), 134'(1));
        alf = 1'b1;
        repeat (16) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("alf_mid_d%0d_one_pkt", k), 134'(obs_v[k].size()), 134'(1));
            check($sformatf("alf_mid_d%0d_left", k), 134'(vq[k][0].size() + vq[k][1].size()), 134'(1));
        end
        alf = 1'b0;
        run_done(200);
        model_run(-1);
        compare("alf_mid");

        // Single 4-word packet: one-cycle pop-to-write latency, keep bit with the tail.
        pop_cyc.delete(); wr_cyc.delete(); vwr_cyc.delete();
        push_pkt(0, 4, 1'b1, 1'b0);
        run_done(100);
        check("lat_npops", 134'(pop_cyc.size()), 134'(4));
        check("lat_nwr", 134'(wr_cyc.size()), 134'(4));
        if (pop_cyc.size() == 4 && wr_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("lat_word%0d", i), 134'(wr_cyc[i]), 134'(pop_cyc[i] + 1));
            check("lat_nvwr", 134'(vwr_cyc.size()), 134'(1));
            if (vwr_cyc.size() == 1) check("lat_vwr_on_tail", 134'(vwr_cyc[0]), 134'(wr_cyc[3]));
        end
        model_run(-1);
        compare("single");

        // Source 1 arrives while source 0 is mid-packet.
        push_pkt(0, 6, 1'b1, 1'b0);
        push_pkt(0, 3, 1'b1, 1'b0);
        n = 0;
        while ((obs_w[0].size() < 1 || obs_w[1].size() < 1) && n < 20) begin tick(); n++; end
        check("prio_started", 134'(obs_w[0].size() >= 1 && obs_w[1].size() >= 1), 134'(1));
        for (int i = 0; i < 3; i++) push_pkt(1, $urandom_range(2, 5), 1'b1, 1'b0);
        run_done(300);
        model_run(0);
        compare("prio");

        // Length guard, exact-limit packet, one over, and a bad head.
        push_pkt(0, 12, 1'b1, 1'b0);
        push_pkt(1, MAXW, 1'b1, 1'b0);
        push_pkt(0, MAXW + 1, 1'b1, 1'b0);
        push_pkt(1, 5, 1'b1, 1'b1);
        run_done(400);
        model_run(-1);
        compare("guard");

        // Three empty cycles mid-packet leave a three-cycle hole in the output.
        pop_cyc.delete(); wr_cyc.delete();
        push_pkt(0, 6, 1'b1, 1'b0);
        n = 0;
        while (pop_cyc.size() < 3 && n < 20) begin tick(); n++; end
        for (int k = 0; k < 2; k++) stall[k][0] = 1'b1;
        refresh();
        repeat (3) tick();
        for (int k = 0; k < 2; k++) stall[k][0] = 1'b0;
        refresh();
        run_done(100);
        check("gap_nwr", 134'(wr_cyc.size()), 134'(6));
        if (wr_cyc.size() >= 4) check("gap_len", 134'(wr_cyc[3] - wr_cyc[2]), 134'(4));
        model_run(-1);
        compare("gap");

        // Randomized rounds with random FIFO underflow.
        rnd_stall = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < 2; s++) begin
                n = $urandom_range(0, 3);
                for (int i = 0; i < n; i++)
                    push_pkt(s, $urandom_range(2, 12), 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 7) == 0));
            end
            run_done(3000);
            model_run(-1);
            compare($sformatf("rnd%0d", r));
        end
        rnd_stall = 1'b0;
        for (int k = 0; k < 2; k++) for (int s = 0; s < 2; s++) stall[k][s] = 1'b0;
        refresh();

        // Reset in the middle of a packet.
        push_pkt(0, 7, 1'b1, 1'b0);
        n = 0;
        while (obs_w[0].size() < 3 && n < 20) begin tick(); n++; end
        rst = 1'b1;
        tick();
        check_outputs_zero("rst_mid");
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                dq[k][s].delete(); vq[k][s].delete(); pend[k][s].delete();
            end
            obs_w[k].delete(); obs_g[k].delete(); obs_v[k].delete();
            obs_err[k] = 0; mptr[k] = 1'b0;
        end
        refresh();
        tick();
        rst = 1'b0;
        push_pkt(1, 3, 1'b1, 1'b0);
        push_pkt(0, 3, 1'b1, 1'b0);
        run_done(100);
        model_run(-1);
        compare("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
